alarm_clock_core: RTL and testbench

- Parametrised timekeeping and alarm engine for the 24 hr clock.
- Generalises the single-alarm centisecond FSM to N_ALARMS independent alarms, adds snooze and a ring timeout, and replaces the modulo-divide counter with cascaded hh:mm:ss counters.
- Sits between the 100 Hz clock domain and the digit/SSD decode; outputs binary hours/minutes/seconds plus alarm status.

---
 rtl/clock_pkg.sv | 28 ++
 rtl/edge_pulse.sv | 19 +
 rtl/alarm_clock_core.sv | 215 +++++++++++++++++++++
 tb/tb_alarm_clock_core.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared mode encodings, field widths, ring FSM state and wrap-around helpers.
// No logic of its own.
package clock_pkg;

    localparam logic [1:0] MODE_RUN       = 2'd0;
    localparam logic [1:0] MODE_SET_CLOCK = 2'd1;
    localparam logic [1:0] MODE_SET_ALARM = 2'd2;
    localparam logic [1:0] MODE_RUN_ALT   = 2'd3;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } ring_state_t;

    function automatic logic [MIN_W-1:0] inc_mod60(input logic [MIN_W-1:0] v);
        return (v == MIN_W'(59)) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [HR_W-1:0] inc_mod24(input logic [HR_W-1:0] v);
        return (v == HR_W'(23)) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector; pulse is combinational from din and the one-cycle history.
// Latency 0, no backpressure; history resets to 1 so a level held through reset never fires.
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) prev <= 1'b1;
        else       prev <= din;
    end

    assign pulse = din & ~prev;

endmodule

// File: rtl/alarm_clock_core.sv
// 24 h hh:mm:ss timekeeper with N alarm slots, snooze and ring timeout.
// Edits and state changes land on the sampling posedge, visible next cycle; no backpressure.
module alarm_clock_core
    import clock_pkg::*;
#(
    parameter int  TICKS_PER_SEC    = 100,
    parameter int  N_ALARMS         = 4,
    parameter int  SNOOZE_MIN       = 9,
    parameter int  RING_TIMEOUT_MIN = 5,
    localparam int AW               = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          mode,
    input  logic [AW-1:0]       alarm_sel,
    input  logic [N_ALARMS-1:0] alarm_en,
    input  logic                inc_min,
    input  logic                inc_hr,
    input  logic                stop,
    input  logic                snooze,
    output logic [HR_W-1:0]     disp_hr,
    output logic [MIN_W-1:0]    disp_min,
    output logic [SEC_W-1:0]    disp_sec,
    output logic                ringing,
    output logic                snoozed,
    output logic [AW-1:0]       ring_id
);

    localparam int          SUB_W     = $clog2(TICKS_PER_SEC);
    localparam logic [5:0]  RING_LOAD = 6'(RING_TIMEOUT_MIN);
    localparam logic [5:0]  SNZ_LOAD  = 6'(SNOOZE_MIN);

    logic inc_min_p, inc_hr_p, stop_p, snooze_p;

    edge_pulse u_ep_min (.clk(clk), .reset(reset), .din(inc_min), .pulse(inc_min_p));
    edge_pulse u_ep_hr  (.clk(clk), .reset(reset), .din(inc_hr),  .pulse(inc_hr_p));
    edge_pulse u_ep_stp (.clk(clk), .reset(reset), .din(stop),    .pulse(stop_p));
    edge_pulse u_ep_snz (.clk(clk), .reset(reset), .din(snooze),  .pulse(snooze_p));

    logic              run_mode, sel_ok, edit_en;
    logic [SUB_W-1:0]  sub, sub_n;
    logic [SEC_W-1:0]  sec, sec_n;
    logic [MIN_W-1:0]  min, min_n;
    logic [HR_W-1:0]   hr, hr_n;
    logic              min_roll;

    assign run_mode = (mode == MODE_RUN) || (mode == MODE_RUN_ALT);
    assign sel_ok   = int'(alarm_sel) < N_ALARMS;
    assign edit_en  = (mode == MODE_SET_ALARM) && sel_ok;

    // Cascaded counters; SET_CLOCK freezes sub/sec at 0 and edits without carry.
    always_comb begin
        sub_n    = sub;
        sec_n    = sec;
        min_n    = min;
        hr_n     = hr;
        min_roll = 1'b0;
        if (mode == MODE_SET_CLOCK) begin
            sub_n = '0;
            sec_n = '0;
            if (inc_min_p) min_n = inc_mod60(min);
            if (inc_hr_p)  hr_n  = inc_mod24(hr);
        end else if (sub == SUB_W'(TICKS_PER_SEC - 1)) begin
            sub_n = '0;
            if (sec == SEC_W'(59)) begin
                sec_n    = '0;
                min_n    = inc_mod60(min);
                min_roll = run_mode;
                if (min == MIN_W'(59)) hr_n = inc_mod24(hr);
            end else begin
                sec_n = sec + 1'b1;
            end
        end else begin
            sub_n = sub + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sub <= '0;
            sec <= '0;
            min <= '0;
            hr  <= '0;
        end else begin
            sub <= sub_n;
            sec <= sec_n;
            min <= min_n;
            hr  <= hr_n;
        end
    end

    logic [HR_W-1:0]  alm_hr  [N_ALARMS];
    logic [MIN_W-1:0] alm_min [N_ALARMS];
    logic [HR_W-1:0]  sel_hr_n;
    logic [MIN_W-1:0] sel_min_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                alm_hr[i]  <= '0;
                alm_min[i] <= '0;
            end
        end else if (edit_en) begin
            if (inc_min_p) alm_min[alarm_sel] <= inc_mod60(alm_min[alarm_sel]);
            if (inc_hr_p)  alm_hr[alarm_sel]  <= inc_mod24(alm_hr[alarm_sel]);
        end
    end

    always_comb begin
        sel_hr_n  = '0;
        sel_min_n = '0;
        if (sel_ok) begin
            sel_hr_n  = alm_hr[alarm_sel];
            sel_min_n = alm_min[alarm_sel];
            if (edit_en && inc_hr_p)  sel_hr_n  = inc_mod24(sel_hr_n);
            if (edit_en && inc_min_p) sel_min_n = inc_mod60(sel_min_n);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_hr  <= '0;
            disp_min <= '0;
            disp_sec <= '0;
        end else if (mode == MODE_SET_ALARM) begin
            disp_hr  <= sel_hr_n;
            disp_min <= sel_min_n;
            disp_sec <= '0;
        end else begin
            disp_hr  <= hr_n;
            disp_min <= min_n;
            disp_sec <= sec_n;
        end
    end

    // Descending scan so the lowest matching slot is the one left standing.
    logic          match_vld;
    logic [AW-1:0] match_idx;

    always_comb begin
        match_vld = 1'b0;
        match_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (min_roll && alarm_en[i] && alm_hr[i] == hr_n && alm_min[i] == min_n) begin
                match_vld = 1'b1;
                match_idx = AW'(i);
            end
        end
    end

    ring_state_t   state, state_n;
    logic [5:0]    ring_cnt, ring_cnt_n, snz_cnt, snz_cnt_n;
    logic [AW-1:0] ring_id_n;
    logic          en_lost;

    assign en_lost = !alarm_en[ring_id];

    always_comb begin
        state_n    = state;
        ring_cnt_n = ring_cnt;
        snz_cnt_n  = snz_cnt;
        ring_id_n  = ring_id;
        unique case (state)
            IDLE: begin
                if (match_vld) begin
                    state_n    = RINGING;
                    ring_cnt_n = RING_LOAD;
                    ring_id_n  = match_idx;
                end
            end
            RINGING: begin
                if (en_lost || stop_p) begin
                    state_n = IDLE;
                end else if (snooze_p) begin
                    state_n   = SNOOZED;
                    snz_cnt_n = SNZ_LOAD;
                end else if (min_roll) begin
                    ring_cnt_n = ring_cnt - 1'b1;
                    if (ring_cnt == 6'd1) state_n = IDLE;
                end
            end
            SNOOZED: begin
                if (en_lost || stop_p) begin
                    state_n = IDLE;
                end else if (min_roll) begin
                    if (snz_cnt == 6'd1) begin
                        state_n    = RINGING;
                        ring_cnt_n = RING_LOAD;
                    end else begin
                        snz_cnt_n = snz_cnt - 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            ring_id  <= '0;
        end else begin
            state    <= state_n;
            ring_cnt <= ring_cnt_n;
            snz_cnt  <= snz_cnt_n;
            ring_id  <= ring_id_n;
        end
    end

    assign ringing = (state == RINGING);
    assign snoozed = (state == SNOOZED);

endmodule

// File: tb/tb_alarm_clock_core.sv
// Directed scenarios for alarm_clock_core; expectations are queued by the stimulus
// and drained against the outputs by a negedge monitor.
module tb_alarm_clock_core;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic [1:0] alarm_sel;
    logic [3:0] alarm_en;
    logic       inc_min, inc_hr, stop, snooze;
    logic [4:0] disp_hr;
    logic [5:0] disp_min, disp_sec;
    logic       ringing, snoozed;
    logic [1:0] ring_id;

    alarm_clock_core #(
        .TICKS_PER_SEC(4), .N_ALARMS(4), .SNOOZE_MIN(2), .RING_TIMEOUT_MIN(3)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .alarm_sel(alarm_sel),
        .alarm_en(alarm_en), .inc_min(inc_min), .inc_hr(inc_hr),
        .stop(stop), .snooze(snooze), .disp_hr(disp_hr), .disp_min(disp_min),
        .disp_sec(disp_sec), .ringing(ringing), .snoozed(snoozed), .ring_id(ring_id)
    );

    always #5 clk = ~clk;

    localparam int F_HR = 0, F_MIN = 1, F_SEC = 2, F_RING = 3, F_SNZ = 4, F_ID = 5;

    typedef struct {
        string name;
        int    field;
        int    val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int observe(input int f);
        case (f)
            F_HR:    return int'(disp_hr);
            F_MIN:   return int'(disp_min);
            F_SEC:   return int'(disp_sec);
            F_RING:  return int'(ringing);
            F_SNZ:   return int'(snoozed);
            default: return int'(ring_id);
        endcase
    endfunction

    task automatic exp_push(input string nm, input int f, input int v);
        exp_t e;
        e.name  = nm;
        e.field = f;
        e.val   = v;
        sb_q.push_back(e);
    endtask

    task automatic exp_time(input string nm, input int h, input int m, input int s);
        exp_push({nm, "_hr"},  F_HR,  h);
        exp_push({nm, "_min"}, F_MIN, m);
        exp_push({nm, "_sec"}, F_SEC, s);
    endtask

    task automatic exp_ring(input string nm, input int r, input int s);
        exp_push({nm, "_ringing"}, F_RING, r);
        exp_push({nm, "_snoozed"}, F_SNZ,  s);
    endtask

    // Monitor: compares every queued expectation against the settled outputs.
    always @(negedge clk) begin
        exp_t e;
        int   act;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = observe(e.field);
            checks++;
            if (act != e.val) begin
                errors++;
                $display("FAIL %s: got %0d, expected %0d", e.name, act, e.val);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic v);
        case (which)
            0:       inc_min = v;
            1:       inc_hr  = v;
            2:       stop    = v;
            default: snooze  = v;
        endcase
    endtask

    task automatic press(input int which);
        drive(which, 1'b1);
        step(1);
        drive(which, 1'b0);
        step(1);
    endtask

    task automatic wait_ring(input int budget);
        int n;
        n = 0;
        while (!ringing && n < budget) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        reset = 1'b1; mode = 2'd1; alarm_sel = 2'd0; alarm_en = 4'b0000;
        inc_min = 1'b0; inc_hr = 1'b1; stop = 1'b0; snooze = 1'b0;
        step(3);
        exp_time("reset", 0, 0, 0);
        exp_ring("reset", 0, 0);
        exp_push("reset_ring_id", F_ID, 0);

        // Button held through reset must not fire; a fresh edge must.
        reset = 1'b0;
        step(5);
        exp_push("hold_through_reset_hr", F_HR, 0);
        inc_hr = 1'b0; step(1);
        inc_hr = 1'b1; step(1);
        exp_push("fresh_edge_hr", F_HR, 1);
        inc_hr = 1'b0; step(1);

        repeat (22) press(1);
        repeat (58) press(0);
        exp_push("set_23_hr", F_HR, 23);
        exp_push("set_58_min", F_MIN, 58);
        inc_min = 1'b1; inc_hr = 1'b1; step(1);
        exp_time("both_edges", 0, 59, 0);
        inc_min = 1'b0; inc_hr = 1'b0; step(1);
        repeat (23) press(1);
        exp_time("set_2359", 23, 59, 0);

        mode = 2'd0;
        step(239);
        exp_time("pre_midnight", 23, 59, 59);
        step(1);
        exp_time("midnight", 0, 0, 0);
        checks++;
        if (disp_hr !== 5'd0 || disp_min !== 6'd0 || disp_sec !== 6'd0) begin
            errors++;
            $display("FAIL midnight_direct: got %0d:%0d:%0d", disp_hr, disp_min, disp_sec);
        end

        // Held inc_min gives a single minute step.
        mode = 2'd1; inc_min = 1'b1;
        step(10);
        inc_min = 1'b0; step(1);
        exp_time("held_inc_min", 0, 1, 0);

        mode = 2'd2; alarm_sel = 2'd1; press(0);
        alarm_sel = 2'd3; press(0);
        exp_time("alarm3_disp", 0, 1, 0);
        mode = 2'd1;
        repeat (59) press(0);
        exp_time("back_to_0000", 0, 0, 0);

        // Slots 1 and 3 both match 00:01; slot 1 must win.
        alarm_en = 4'b1010; mode = 2'd0;
        step(239);
        exp_push("pre_match_ringing", F_RING, 0);
        exp_push("pre_match_sec", F_SEC, 59);
        step(1);
        exp_ring("match", 1, 0);
        exp_push("match_ring_id", F_ID, 1);
        exp_time("match", 0, 1, 0);
        checks++;
        if (ringing !== 1'b1 || ring_id !== 2'd1) begin
            errors++;
            $display("FAIL match_direct: ringing=%0b ring_id=%0d", ringing, ring_id);
        end

        snooze = 1'b1; step(1);
        exp_ring("snooze", 0, 1);
        snooze = 1'b0;
        step(478);
        exp_ring("snooze_pending", 0, 1);
        step(1);
        exp_ring("snooze_expired", 1, 0);
        exp_push("snooze_ring_id", F_ID, 1);
        exp_push("snooze_expired_min", F_MIN, 3);

        step(719);
        exp_push("pre_timeout_ringing", F_RING, 1);
        step(1);
        exp_ring("timeout", 0, 0);
        exp_time("timeout", 0, 6, 0);

        mode = 2'd2; alarm_sel = 2'd0;
        repeat (7) press(0);
        exp_push("alarm0_disp_min", F_MIN, 7);
        alarm_en = 4'b1011; mode = 2'd0;
        wait_ring(300);
        exp_push("retrigger_ringing", F_RING, 1);
        exp_push("retrigger_ring_id", F_ID, 0);
        exp_time("retrigger", 0, 7, 0);

        stop = 1'b1; snooze = 1'b1; step(1);
        exp_ring("stop_beats_snooze", 0, 0);
        stop = 1'b0; snooze = 1'b0; step(1);

        mode = 2'd2; alarm_sel = 2'd0; press(0);
        exp_push("alarm0_disp_min8", F_MIN, 8);
        mode = 2'd0;
        wait_ring(300);
        exp_push("ring08_ringing", F_RING, 1);
        exp_time("ring08", 0, 8, 0);
        alarm_en = 4'b1010; step(1);
        exp_ring("disable", 0, 0);

        // 16 cycles after the 00:08:00 edge: time must read 00:08:04.
        mode = 2'd2; alarm_sel = 2'd2;
        repeat (5) press(0);
        exp_time("alarm2_edit", 0, 5, 0);
        alarm_sel = 2'd0; step(1);
        exp_push("alarm0_kept", F_MIN, 8);
        alarm_sel = 2'd1; step(1);
        exp_push("alarm1_kept", F_MIN, 1);
        alarm_sel = 2'd3; step(1);
        exp_push("alarm3_kept", F_MIN, 1);
        mode = 2'd0; step(2);
        exp_time("time_advanced", 0, 8, 4);

        step(2);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard not drained: %0d pending", sb_q.size());
        end
        if (checks < 12) begin
            errors++;
            $display("FAIL too few checks executed: %0d", checks);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
